// File: rtl/dispatch_scheduler_if.sv
// Aligner-side and issue-queue-side signals of the dispatch scheduler.
// The slave modport is the scheduler's view; the master modport is the environment's.
interface dispatch_scheduler_if #(
  parameter int INSN_WIDTH = 99
);
  logic                  i_flush;
  logic [3:0]            i_valid;
  logic [INSN_WIDTH-1:0] i_isn1;
  logic [INSN_WIDTH-1:0] i_isn2;
  logic [INSN_WIDTH-1:0] i_isn3;
  logic [INSN_WIDTH-1:0] i_isn4;
  logic                  o_Stall;
  logic                  i_alu_ready;
  logic                  o_alu_valid;
  logic [INSN_WIDTH-1:0] o_alu_isn;
  logic                  i_mem_ready;
  logic                  o_mem_valid;
  logic [INSN_WIDTH-1:0] o_mem_isn;
  logic                  o_busy;

  modport slave (
    input  i_flush, i_valid, i_isn1, i_isn2, i_isn3, i_isn4, i_alu_ready, i_mem_ready,
    output o_Stall, o_alu_valid, o_alu_isn, o_mem_valid, o_mem_isn, o_busy
  );

  modport master (
    output i_flush, i_valid, i_isn1, i_isn2, i_isn3, i_isn4, i_alu_ready, i_mem_ready,
    input  o_Stall, o_alu_valid, o_alu_isn, o_mem_valid, o_mem_isn, o_busy
  );
endinterface

// File: rtl/dispatch_scheduler.sv
// Dispatch scheduler: captures one 4-slot aligned bundle and drains it in program
// order into the ALU and MEM issue queues, at most one instruction per queue per cycle.
module dispatch_scheduler #(
  parameter int INSN_WIDTH = 99,
  parameter int QSEL_BIT   = 0
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  dispatch_scheduler_if.slave    bus
);

  typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_pending;
  logic [INSN_WIDTH-1:0] r_isn [4];

  logic       w_a_has, w_b_has;
  logic [1:0] w_a_idx, w_b_idx;
  logic [3:0] w_rest;
  logic       w_a_q, w_b_q;
  logic       w_a_go, w_b_go;
  logic [3:0] w_disp, w_remain;
  logic       w_accept, w_load;

  // Locate the oldest pending slot (A) and the next pending slot after it (B).
  always_comb begin
    w_a_has = 1'b0;
    w_a_idx = 2'd0;
    w_b_has = 1'b0;
    w_b_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r_pending[k]) begin
        w_a_has = 1'b1;
        w_a_idx = 2'(k);
      end
    end
    w_rest = r_pending & ~(4'b0001 << w_a_idx);
    for (int k = 3; k >= 0; k--) begin
      if (w_rest[k]) begin
        w_b_has = 1'b1;
        w_b_idx = 2'(k);
      end
    end
  end

  // Decide which of A/B dispatch this cycle and whether a new bundle can be taken.
  always_comb begin
    w_a_q    = r_isn[w_a_idx][QSEL_BIT];
    w_b_q    = r_isn[w_b_idx][QSEL_BIT];
    // B may only ride along when A went and it targets the other queue.
    w_a_go   = (r_state == S_HOLD) && w_a_has && !bus.i_flush &&
               (w_a_q ? bus.i_mem_ready : bus.i_alu_ready);
    w_b_go   = w_a_go && w_b_has && (w_b_q != w_a_q) &&
               (w_b_q ? bus.i_mem_ready : bus.i_alu_ready);
    w_disp   = ({3'b000, w_a_go} << w_a_idx) | ({3'b000, w_b_go} << w_b_idx);
    w_remain = r_pending & ~w_disp;
    // Accepting on the draining cycle lets the next bundle load with no bubble.
    w_accept = (r_state == S_EMPTY) || (w_remain == 4'b0000);
    w_load   = w_accept && (bus.i_valid != 4'b0000) && !bus.i_flush;
  end

  // State register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_state <= S_EMPTY;
    else         r_state <= w_next_state;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    w_next_state = r_state;
    if (bus.i_flush) begin
      w_next_state = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_load) w_next_state = S_HOLD;
        S_HOLD:  if (w_remain == 4'b0000) w_next_state = w_load ? S_HOLD : S_EMPTY;
        default: w_next_state = S_EMPTY;
      endcase
    end
  end

  // Bundle capture and pending-mask retirement of dispatched slots.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_pending <= 4'b0000;
      for (int k = 0; k < 4; k++) r_isn[k] <= '0;
    end else if (bus.i_flush) begin
      r_pending <= 4'b0000;
    end else if (w_load) begin
      r_pending <= bus.i_valid;
      r_isn[0]  <= bus.i_isn1;
      r_isn[1]  <= bus.i_isn2;
      r_isn[2]  <= bus.i_isn3;
      r_isn[3]  <= bus.i_isn4;
    end else begin
      r_pending <= w_remain;
    end
  end

  // Route dispatched slots to their queue ports; idle ports read as zero.
  always_comb begin
    bus.o_busy      = (r_state == S_HOLD);
    bus.o_Stall     = !bus.i_flush && !w_accept;
    bus.o_alu_valid = 1'b0;
    bus.o_alu_isn   = '0;
    bus.o_mem_valid = 1'b0;
    bus.o_mem_isn   = '0;
    if (w_a_go) begin
      if (w_a_q) begin
        bus.o_mem_valid = 1'b1;
        bus.o_mem_isn   = r_isn[w_a_idx];
      end else begin
        bus.o_alu_valid = 1'b1;
        bus.o_alu_isn   = r_isn[w_a_idx];
      end
    end
    if (w_b_go) begin
      if (w_b_q) begin
        bus.o_mem_valid = 1'b1;
        bus.o_mem_isn   = r_isn[w_b_idx];
      end else begin
        bus.o_alu_valid = 1'b1;
        bus.o_alu_isn   = r_isn[w_b_idx];
      end
    end
  end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Testbench for dispatch_scheduler: directed scenarios plus randomized traffic
// compared against an instruction-queue reference model.
module tb_dispatch_scheduler;
  localparam int W = 99;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_scheduler_if #(.INSN_WIDTH(W)) dut_if ();

  dispatch_scheduler #(.INSN_WIDTH(W), .QSEL_BIT(0)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (dut_if.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] ins [4];
  logic [W-1:0] mq [$];

  function automatic logic [W-1:0] mk(input int tag, input bit q);
    logic [W-1:0] v;
    v = '0;
    v[32:1] = tag;
    v[0] = q;
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_insn();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bundle(input logic [3:0] v);
    dut_if.i_isn1  = ins[0];
    dut_if.i_isn2  = ins[1];
    dut_if.i_isn3  = ins[2];
    dut_if.i_isn4  = ins[3];
    dut_if.i_valid = v;
  endtask

  task automatic idle_inputs();
    dut_if.i_flush     = 1'b0;
    dut_if.i_valid     = 4'b0000;
    dut_if.i_alu_ready = 1'b1;
    dut_if.i_mem_ready = 1'b1;
    dut_if.i_isn1 = '0; dut_if.i_isn2 = '0; dut_if.i_isn3 = '0; dut_if.i_isn4 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #3;
    total++; if (dut_if.o_alu_valid !== 1'b0) begin bad++; $display("FAIL rst_alu_v got=%0b exp=0", dut_if.o_alu_valid); end
    total++; if (dut_if.o_mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_v got=%0b exp=0", dut_if.o_mem_valid); end
    total++; if (dut_if.o_Stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", dut_if.o_Stall); end
    total++; if (dut_if.o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", dut_if.o_busy); end
    total++; if (dut_if.o_alu_isn !== '0 || dut_if.o_mem_isn !== '0) begin bad++; $display("FAIL rst_isn got=%0h/%0h exp=0", dut_if.o_alu_isn, dut_if.o_mem_isn); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_all_alu();
    for (int i = 0; i < 4; i++) ins[i] = mk(16 + i, 1'b0);
    drive_bundle(4'b1111);
    #1;
    total++; if (dut_if.o_Stall !== 1'b0 || dut_if.o_alu_valid !== 1'b0) begin bad++; $display("FAIL t1_capture got stall=%0b alu_v=%0b exp=0/0", dut_if.o_Stall, dut_if.o_alu_valid); end
    step();
    dut_if.i_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (dut_if.o_alu_valid !== 1'b1 || dut_if.o_alu_isn !== ins[i]) begin bad++; $display("FAIL t1_alu%0d got v=%0b isn=%0h exp v=1 isn=%0h", i, dut_if.o_alu_valid, dut_if.o_alu_isn, ins[i]); end
      total++; if (dut_if.o_mem_valid !== 1'b0) begin bad++; $display("FAIL t1_mem%0d got=%0b exp=0", i, dut_if.o_mem_valid); end
      total++; if (dut_if.o_Stall !== (i < 3)) begin bad++; $display("FAIL t1_stall%0d got=%0b exp=%0b", i, dut_if.o_Stall, (i < 3)); end
      total++; if (dut_if.o_busy !== 1'b1) begin bad++; $display("FAIL t1_busy%0d got=%0b exp=1", i, dut_if.o_busy); end
      step();
    end
    #1;
    total++; if (dut_if.o_busy !== 1'b0 || dut_if.o_alu_valid !== 1'b0) begin bad++; $display("FAIL t1_end got busy=%0b alu_v=%0b exp=0/0", dut_if.o_busy, dut_if.o_alu_valid); end
    step();
  endtask

  task automatic test_pairs();
    for (int i = 0; i < 4; i++) ins[i] = mk(32 + i, i[0]);
    drive_bundle(4'b1111);
    step();
    dut_if.i_valid = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (dut_if.o_alu_valid !== 1'b1 || dut_if.o_alu_isn !== ins[2*i]) begin bad++; $display("FAIL t2_alu%0d got v=%0b isn=%0h exp isn=%0h", i, dut_if.o_alu_valid, dut_if.o_alu_isn, ins[2*i]); end
      total++; if (dut_if.o_mem_valid !== 1'b1 || dut_if.o_mem_isn !== ins[2*i+1]) begin bad++; $display("FAIL t2_mem%0d got v=%0b isn=%0h exp isn=%0h", i, dut_if.o_mem_valid, dut_if.o_mem_isn, ins[2*i+1]); end
      total++; if (dut_if.o_Stall !== (i == 0)) begin bad++; $display("FAIL t2_stall%0d got=%0b exp=%0b", i, dut_if.o_Stall, (i == 0)); end
      step();
    end
    #1;
    total++; if (dut_if.o_busy !== 1'b0) begin bad++; $display("FAIL t2_end got busy=%0b exp=0", dut_if.o_busy); end
    step();
  endtask

  task automatic test_mem_block();
    ins[0] = mk(48, 1'b1); ins[1] = mk(49, 1'b0); ins[2] = mk(50, 1'b0); ins[3] = mk(51, 1'b1);
    drive_bundle(4'b0011);
    step();
    dut_if.i_valid     = 4'b0000;
    dut_if.i_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (dut_if.o_alu_valid !== 1'b0 || dut_if.o_mem_valid !== 1'b0) begin bad++; $display("FAIL t3_block%0d got alu_v=%0b mem_v=%0b exp=0/0", i, dut_if.o_alu_valid, dut_if.o_mem_valid); end
      total++; if (dut_if.o_alu_isn !== '0) begin bad++; $display("FAIL t3_isn%0d got=%0h exp=0", i, dut_if.o_alu_isn); end
      total++; if (dut_if.o_Stall !== 1'b1) begin bad++; $display("FAIL t3_stall%0d got=%0b exp=1", i, dut_if.o_Stall); end
      step();
    end
    dut_if.i_mem_ready = 1'b1;
    #1;
    total++; if (dut_if.o_mem_valid !== 1'b1 || dut_if.o_mem_isn !== ins[0]) begin bad++; $display("FAIL t3_mem got v=%0b isn=%0h exp isn=%0h", dut_if.o_mem_valid, dut_if.o_mem_isn, ins[0]); end
    total++; if (dut_if.o_alu_valid !== 1'b1 || dut_if.o_alu_isn !== ins[1]) begin bad++; $display("FAIL t3_alu got v=%0b isn=%0h exp isn=%0h", dut_if.o_alu_valid, dut_if.o_alu_isn, ins[1]); end
    total++; if (dut_if.o_Stall !== 1'b0) begin bad++; $display("FAIL t3_stall_rel got=%0b exp=0", dut_if.o_Stall); end
    step();
    #1;
    total++; if (dut_if.o_busy !== 1'b0) begin bad++; $display("FAIL t3_end got busy=%0b exp=0", dut_if.o_busy); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] nb;
    ins[0] = mk(64, 1'b1); ins[1] = mk(65, 1'b0); ins[2] = mk(66, 1'b0); ins[3] = mk(67, 1'b1);
    drive_bundle(4'b1010);
    step();
    nb = mk(80, 1'b0);
    dut_if.i_isn1  = nb;
    dut_if.i_valid = 4'b0001;
    #1;
    total++; if (dut_if.o_alu_valid !== 1'b1 || dut_if.o_alu_isn !== ins[1]) begin bad++; $display("FAIL t4_alu got v=%0b isn=%0h exp isn=%0h", dut_if.o_alu_valid, dut_if.o_alu_isn, ins[1]); end
    total++; if (dut_if.o_mem_valid !== 1'b1 || dut_if.o_mem_isn !== ins[3]) begin bad++; $display("FAIL t4_mem got v=%0b isn=%0h exp isn=%0h", dut_if.o_mem_valid, dut_if.o_mem_isn, ins[3]); end
    total++; if (dut_if.o_Stall !== 1'b0) begin bad++; $display("FAIL t4_stall got=%0b exp=0", dut_if.o_Stall); end
    step();
    dut_if.i_valid = 4'b0000;
    #1;
    total++; if (dut_if.o_alu_valid !== 1'b1 || dut_if.o_alu_isn !== nb) begin bad++; $display("FAIL t4_next got v=%0b isn=%0h exp isn=%0h", dut_if.o_alu_valid, dut_if.o_alu_isn, nb); end
    total++; if (dut_if.o_busy !== 1'b1 || dut_if.o_mem_valid !== 1'b0) begin bad++; $display("FAIL t4_next_state got busy=%0b mem_v=%0b exp=1/0", dut_if.o_busy, dut_if.o_mem_valid); end
    step();
    #1;
    total++; if (dut_if.o_busy !== 1'b0) begin bad++; $display("FAIL t4_end got busy=%0b exp=0", dut_if.o_busy); end
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) ins[i] = mk(96 + i, i[0]);
    drive_bundle(4'b1111);
    step();
    for (int i = 0; i < 4; i++) ins[i] = mk(112 + i, 1'b0);
    drive_bundle(4'b1111);
    dut_if.i_flush = 1'b1;
    #1;
    total++; if (dut_if.o_alu_valid !== 1'b0 || dut_if.o_mem_valid !== 1'b0) begin bad++; $display("FAIL t5_strobe got alu_v=%0b mem_v=%0b exp=0/0", dut_if.o_alu_valid, dut_if.o_mem_valid); end
    total++; if (dut_if.o_Stall !== 1'b0) begin bad++; $display("FAIL t5_stall got=%0b exp=0", dut_if.o_Stall); end
    step();
    dut_if.i_flush = 1'b0;
    dut_if.i_valid = 4'b0000;
    #1;
    total++; if (dut_if.o_busy !== 1'b0 || dut_if.o_alu_valid !== 1'b0 || dut_if.o_mem_valid !== 1'b0) begin bad++; $display("FAIL t5_after got busy=%0b alu_v=%0b mem_v=%0b exp=0/0/0", dut_if.o_busy, dut_if.o_alu_valid, dut_if.o_mem_valid); end
    step();
    #1;
    total++; if (dut_if.o_busy !== 1'b0 || dut_if.o_alu_valid !== 1'b0) begin bad++; $display("FAIL t5_dropped got busy=%0b alu_v=%0b exp=0/0", dut_if.o_busy, dut_if.o_alu_valid); end
    step();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) ins[i] = mk(128 + i, 1'b0);
    drive_bundle(4'b1111);
    step();
    dut_if.i_valid = 4'b0000;
    #1;
    total++; if (dut_if.o_alu_valid !== 1'b1) begin bad++; $display("FAIL t6_pre got alu_v=%0b exp=1", dut_if.o_alu_valid); end
    rst = 1'b1;
    #1;
    total++; if (dut_if.o_alu_valid !== 1'b0 || dut_if.o_alu_isn !== '0) begin bad++; $display("FAIL t6_async got alu_v=%0b isn=%0h exp=0/0", dut_if.o_alu_valid, dut_if.o_alu_isn); end
    total++; if (dut_if.o_busy !== 1'b0 || dut_if.o_Stall !== 1'b0) begin bad++; $display("FAIL t6_async_ctl got busy=%0b stall=%0b exp=0/0", dut_if.o_busy, dut_if.o_Stall); end
    #2;
    rst = 1'b0;
    step();
    ins[0] = mk(144, 1'b1);
    drive_bundle(4'b0001);
    #1;
    total++; if (dut_if.o_Stall !== 1'b0 || dut_if.o_busy !== 1'b0) begin bad++; $display("FAIL t6_ready got stall=%0b busy=%0b exp=0/0", dut_if.o_Stall, dut_if.o_busy); end
    step();
    dut_if.i_valid = 4'b0000;
    #1;
    total++; if (dut_if.o_mem_valid !== 1'b1 || dut_if.o_mem_isn !== ins[0]) begin bad++; $display("FAIL t6_new got v=%0b isn=%0h exp isn=%0h", dut_if.o_mem_valid, dut_if.o_mem_isn, ins[0]); end
    step();
    #1;
    total++; if (dut_if.o_busy !== 1'b0) begin bad++; $display("FAIL t6_end got busy=%0b exp=0", dut_if.o_busy); end
  endtask

  // Reference: the scheduler is an in-order queue of instructions; each cycle the head
  // goes if its queue is ready, and the second goes too if it targets the other ready queue.
  task automatic test_random();
    logic [W-1:0] h, s;
    logic [3:0] v;
    bit fl, ar, mr, e_av, e_mv, e_st, e_bz;
    logic [W-1:0] e_ai, e_mi;
    int n, nd;
    mq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v  = (($urandom % 4) == 0) ? 4'b0000 : 4'($urandom % 16);
      fl = (($urandom % 16) == 0);
      ar = (($urandom % 4) != 0);
      mr = (($urandom % 4) != 0);
      for (int i = 0; i < 4; i++) ins[i] = rnd_insn();
      drive_bundle(v);
      dut_if.i_flush     = fl;
      dut_if.i_alu_ready = ar;
      dut_if.i_mem_ready = mr;
      n = mq.size(); nd = 0;
      e_av = 0; e_mv = 0; e_ai = '0; e_mi = '0;
      if (!fl && n > 0) begin
        h = mq[0];
        if (h[0] ? mr : ar) begin
          nd = 1;
          if (h[0]) begin e_mv = 1; e_mi = h; end else begin e_av = 1; e_ai = h; end
          if (n > 1) begin
            s = mq[1];
            if (s[0] != h[0] && (s[0] ? mr : ar)) begin
              nd = 2;
              if (s[0]) begin e_mv = 1; e_mi = s; end else begin e_av = 1; e_ai = s; end
            end
          end
        end
      end
      e_st = !fl && (n - nd != 0);
      e_bz = (n != 0);
      #1;
      total++; if (dut_if.o_alu_valid !== e_av) begin bad++; $display("FAIL rnd_alu_v c%0d got=%0b exp=%0b", cyc, dut_if.o_alu_valid, e_av); end
      total++; if (dut_if.o_alu_isn !== e_ai) begin bad++; $display("FAIL rnd_alu_isn c%0d got=%0h exp=%0h", cyc, dut_if.o_alu_isn, e_ai); end
      total++; if (dut_if.o_mem_valid !== e_mv) begin bad++; $display("FAIL rnd_mem_v c%0d got=%0b exp=%0b", cyc, dut_if.o_mem_valid, e_mv); end
      total++; if (dut_if.o_mem_isn !== e_mi) begin bad++; $display("FAIL rnd_mem_isn c%0d got=%0h exp=%0h", cyc, dut_if.o_mem_isn, e_mi); end
      total++; if (dut_if.o_Stall !== e_st) begin bad++; $display("FAIL rnd_stall c%0d got=%0b exp=%0b", cyc, dut_if.o_Stall, e_st); end
      total++; if (dut_if.o_busy !== e_bz) begin bad++; $display("FAIL rnd_busy c%0d got=%0b exp=%0b", cyc, dut_if.o_busy, e_bz); end
      @(posedge clk);
      if (fl) begin
        mq.delete();
      end else begin
        repeat (nd) void'(mq.pop_front());
        if (mq.size() == 0 && v != 4'b0000)
          for (int k = 0; k < 4; k++) if (v[k]) mq.push_back(ins[k]);
      end
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_alu();
    test_pairs();
    test_mem_block();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
